game_timer_ctrl: RTL and testbench
==================================

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: tick_1ms  input  1  one-cycle pulse, one per millisecond, from the prescaler.
REQ-004 SHALL provide: start  input  1  one-cycle pulse requesting a new timed round.
REQ-005 SHALL provide: pause_tgl  input  1  one-cycle pulse toggling between run and pause.
REQ-006 SHALL provide: abort  input  1  one-cycle pulse cancelling the round.
REQ-007 SHALL provide: limit  input  6  round length in seconds (1-63), sampled only on an accepted start.
REQ-008 SHALL provide: secs_left  output  6  remaining whole seconds, registered.
REQ-009 SHALL provide: running  output  1  high while in RUN, registered.
REQ-010 SHALL provide: paused  output  1  high while in PAUSE, registered.
REQ-011 SHALL provide: done  output  1  high while in DONE, registered.
REQ-012 SHALL provide: expired  output  1  one-cycle pulse on the RUN->DONE transition, registered.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, RUN, PAUSE, DONE.
REQ-014 SHALL hold an internal 3-stage decade chain (ms_u, ms_t, ms_h; each 4 bits, range 0-9) counting 1000 ticks per second.
REQ-015 IDLE: start with limit != 0 -> RUN next cycle; secs_left <= limit; decade chain <= 0.
REQ-016 IDLE: start with limit == 0 SHALL be ignored (remain IDLE, secs_left stays 0).
REQ-017 RUN: each tick_1ms SHALL increment ms_u; ms_u 9->0 carries into ms_t; ms_t 9->0 carries into ms_h; ms_h 9->0 is the second boundary.
REQ-018 RUN: at the second boundary, secs_left SHALL decrement by 1 in the same clock edge that wraps the chain to 000.
REQ-019 RUN: when secs_left decrements 1->0 -> DONE; expired = 1 for exactly that next cycle; decade chain = 0.
REQ-020 Latency: limit = N SHALL reach DONE exactly N*1000 accepted ticks after entering RUN.
REQ-021 RUN: pause_tgl -> PAUSE; a tick_1ms in the same cycle SHALL still be counted before pausing.
REQ-022 PAUSE: tick_1ms ignored; decade chain and secs_left held; pause_tgl -> RUN, resuming from held values.
REQ-023 DONE: secs_left = 0, done = 1 held until start (behaves as REQ-015/016) or abort (-> IDLE).
REQ-024 abort in RUN, PAUSE or DONE SHALL -> IDLE next cycle, secs_left <= 0, decade chain <= 0, no expired pulse.
REQ-025 Priority when inputs coincide: abort > start > pause_tgl > tick_1ms.
REQ-026 start while in RUN or PAUSE SHALL be ignored; pause_tgl in IDLE or DONE SHALL be ignored.
REQ-027 Decade counters SHALL never hold values 10-15; secs_left SHALL never underflow below 0.
REQ-028 Outputs: running, paused and done SHALL be one-hot or all-zero (all-zero only in IDLE).

Reset
REQ-029 rst = 0 SHALL immediately, without waiting for clk, force state IDLE, decade chain 0, secs_left 0, running/paused/done/expired 0.
REQ-030 Reset asserted mid-round (RUN or PAUSE) SHALL discard the round; no expired pulse after release.
REQ-031 After rst returns to 1, the block SHALL accept start on the first rising clk edge.

Verification
REQ-032 limit=3, start, continuous ticks -> secs_left 3,2,1 at ticks 1000/2000; DONE and expired single pulse after tick 3000; done held.
REQ-033 limit=2, start, 500 ticks, pause_tgl, 700 more ticks, pause_tgl, ticks resume -> secs_left still 2 during pause; DONE after 2000 counted ticks total.
REQ-034 limit=0, start -> remains IDLE, running=0, secs_left=0.
REQ-035 RUN with limit=5, abort and tick_1ms same cycle -> IDLE, secs_left=0, expired never asserts.
REQ-036 rst pulled low between clk edges during RUN -> outputs clear asynchronously; after release, start with limit=1 completes in 1000 ticks.
REQ-037 In DONE, start with limit=1 -> RUN with secs_left=1, done=0; pause_tgl and start pulses in RUN ignored/handled per REQ-021/026.

Source files
------------

// File: rtl/game_timer_ctrl_if.sv
// Control and status bundle between the round controller and its host.
// The host drives the pulses and the round length; the timer drives the status.
interface game_timer_ctrl_if;
  logic       tick_1ms;
  logic       start;
  logic       pause_tgl;
  logic       abort;
  logic [5:0] limit;
  logic [5:0] secs_left;
  logic       running;
  logic       paused;
  logic       done;
  logic       expired;

  modport master (
    output tick_1ms, start, pause_tgl, abort, limit,
    input  secs_left, running, paused, done, expired
  );

  modport slave (
    input  tick_1ms, start, pause_tgl, abort, limit,
    output secs_left, running, paused, done, expired
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// Round timer: counts 1 ms ticks through a BCD ms chain and counts whole seconds down.
// The FSM supports IDLE/RUN/PAUSE/DONE; all status outputs are registered.
module game_timer_ctrl (
  input logic         clk,
  input logic         rst,
  game_timer_ctrl_if.slave bus
);
  localparam int unsigned SECW = 6;
  localparam int unsigned DECW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [DECW-1:0] DEC_MAX = DECW'(9);

  logic [1:0]      state, state_nxt;
  logic [DECW-1:0] ms_u, ms_t, ms_h;
  logic [DECW-1:0] ms_u_nxt, ms_t_nxt, ms_h_nxt;
  logic [SECW-1:0] secs, secs_nxt;
  logic            running, paused, done, expired;
  logic            expired_nxt;
  logic            start_ok;

  assign start_ok = bus.start && (bus.limit != '0);

  // Next-state and next-output logic; priority abort > start > pause_tgl > tick_1ms
  always_comb begin
    state_nxt   = state;
    ms_u_nxt    = ms_u;
    ms_t_nxt    = ms_t;
    ms_h_nxt    = ms_h;
    secs_nxt    = secs;
    expired_nxt = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          secs_nxt  = '0;
        end else if (start_ok) begin
          state_nxt = RUN;
          secs_nxt  = bus.limit;
          ms_u_nxt  = '0;
          ms_t_nxt  = '0;
          ms_h_nxt  = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          secs_nxt  = '0;
          ms_u_nxt  = '0;
          ms_t_nxt  = '0;
          ms_h_nxt  = '0;
        end else begin
          if (bus.tick_1ms) begin
            if (ms_u != DEC_MAX) begin
              ms_u_nxt = ms_u + DECW'(1);
            end else begin
              ms_u_nxt = '0;
              if (ms_t != DEC_MAX) begin
                ms_t_nxt = ms_t + DECW'(1);
              end else begin
                ms_t_nxt = '0;
                if (ms_h != DEC_MAX) begin
                  ms_h_nxt = ms_h + DECW'(1);
                end else begin
                  // Second boundary: chain wraps to 000 on the same edge
                  ms_h_nxt = '0;
                  if (secs <= SECW'(1)) begin
                    secs_nxt    = '0;
                    state_nxt   = DONE;
                    expired_nxt = 1'b1;
                  end else begin
                    secs_nxt = secs - SECW'(1);
                  end
                end
              end
            end
          end
          if (bus.pause_tgl && (state_nxt == RUN)) begin
            state_nxt = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          secs_nxt  = '0;
          ms_u_nxt  = '0;
          ms_t_nxt  = '0;
          ms_h_nxt  = '0;
        end else if (bus.pause_tgl) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ms_u    <= '0;
      ms_t    <= '0;
      ms_h    <= '0;
      secs    <= '0;
      running <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      ms_u    <= ms_u_nxt;
      ms_t    <= ms_t_nxt;
      ms_h    <= ms_h_nxt;
      secs    <= secs_nxt;
      running <= (state_nxt == RUN);
      paused  <= (state_nxt == PAUSE);
      done    <= (state_nxt == DONE);
      expired <= expired_nxt;
    end
  end

  assign bus.secs_left = secs;
  assign bus.running   = running;
  assign bus.paused    = paused;
  assign bus.done      = done;
  assign bus.expired   = expired;
endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed self-checking bench for game_timer_ctrl; expected values are hand-derived.
module tb_game_timer_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_seen;

  game_timer_ctrl_if bus ();

  game_timer_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which expired is seen high
  always @(negedge clk) begin
    if (bus.expired === 1'b1) exp_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [5:0] l);
    bus.limit = l;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_pause(input logic with_tick);
    bus.pause_tgl = 1'b1;
    bus.tick_1ms  = with_tick;
    step();
    bus.pause_tgl = 1'b0;
    bus.tick_1ms  = 1'b0;
  endtask

  task automatic pulse_abort(input logic with_tick);
    bus.abort    = 1'b1;
    bus.tick_1ms = with_tick;
    step();
    bus.abort    = 1'b0;
    bus.tick_1ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.tick_1ms = 1'b1;
    repeat (n) step();
    bus.tick_1ms = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [5:0] s, input logic r,
                            input logic p, input logic d);
    chk({tag, "_secs"}, 32'(bus.secs_left), 32'(s));
    chk({tag, "_run"},  32'(bus.running),   32'(r));
    chk({tag, "_pause"}, 32'(bus.paused),   32'(p));
    chk({tag, "_done"}, 32'(bus.done),      32'(d));
  endtask

  initial begin
    int exp_base;
    checks        = 0;
    failures      = 0;
    exp_seen      = 0;
    rst           = 1'b1;
    bus.tick_1ms  = 1'b0;
    bus.start     = 1'b0;
    bus.pause_tgl = 1'b0;
    bus.abort     = 1'b0;
    bus.limit     = '0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk_status("reset", 6'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_expired", 32'(bus.expired), 32'd0);
    step();
    @(negedge clk) rst = 1'b1;

    // limit=3 with continuous ticks
    pulse_start(6'd3);
    chk_status("l3_start", 6'd3, 1'b1, 1'b0, 1'b0);
    ticks(999);
    chk("l3_t999_secs", 32'(bus.secs_left), 32'd3);
    ticks(1);
    chk("l3_t1000_secs", 32'(bus.secs_left), 32'd2);
    ticks(1000);
    chk("l3_t2000_secs", 32'(bus.secs_left), 32'd1);
    ticks(999);
    chk_status("l3_t2999", 6'd1, 1'b1, 1'b0, 1'b0);
    chk("l3_t2999_expired", 32'(bus.expired), 32'd0);
    ticks(1);
    chk_status("l3_t3000", 6'd0, 1'b0, 1'b0, 1'b1);
    chk("l3_expired_pulse", 32'(bus.expired), 32'd1);
    step();
    chk("l3_expired_low", 32'(bus.expired), 32'd0);
    chk("l3_done_held", 32'(bus.done), 32'd1);

    // DONE -> start limit=1; pause and start pulses while the round runs
    pulse_start(6'd1);
    chk_status("d_restart", 6'd1, 1'b1, 1'b0, 1'b0);
    ticks(100);
    pulse_pause(1'b0);
    chk_status("d_paused", 6'd1, 1'b0, 1'b1, 1'b0);
    pulse_start(6'd9);
    chk_status("d_start_in_pause", 6'd1, 1'b0, 1'b1, 1'b0);
    pulse_pause(1'b0);
    chk_status("d_resume", 6'd1, 1'b1, 1'b0, 1'b0);
    pulse_start(6'd9);
    chk_status("d_start_in_run", 6'd1, 1'b1, 1'b0, 1'b0);
    ticks(899);
    chk_status("d_t999", 6'd1, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_status("d_t1000", 6'd0, 1'b0, 1'b0, 1'b1);
    chk("d_expired", 32'(bus.expired), 32'd1);

    // abort from DONE, then limit=2 with pauses
    pulse_abort(1'b0);
    chk_status("done_abort", 6'd0, 1'b0, 1'b0, 1'b0);
    pulse_start(6'd2);
    ticks(500);
    pulse_pause(1'b0);
    ticks(700);
    chk_status("l2_paused_ticks", 6'd2, 1'b0, 1'b1, 1'b0);
    pulse_pause(1'b0);
    chk("l2_resumed", 32'(bus.running), 32'd1);
    ticks(499);
    chk("l2_t999_secs", 32'(bus.secs_left), 32'd2);
    pulse_pause(1'b1);
    chk_status("l2_pause_tick", 6'd1, 1'b0, 1'b1, 1'b0);
    pulse_pause(1'b0);
    ticks(999);
    chk_status("l2_t1999", 6'd1, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_status("l2_t2000", 6'd0, 1'b0, 1'b0, 1'b1);
    chk("l2_expired", 32'(bus.expired), 32'd1);

    // limit=0 is ignored in IDLE
    pulse_abort(1'b0);
    pulse_start(6'd0);
    chk_status("l0_ignored", 6'd0, 1'b0, 1'b0, 1'b0);
    pulse_pause(1'b0);
    chk_status("idle_pause_ignored", 6'd0, 1'b0, 1'b0, 1'b0);

    // abort coinciding with a tick during RUN
    exp_base = exp_seen;
    pulse_start(6'd5);
    ticks(1234);
    chk("l5_secs", 32'(bus.secs_left), 32'd4);
    pulse_abort(1'b1);
    chk_status("l5_abort", 6'd0, 1'b0, 1'b0, 1'b0);
    ticks(1000);
    chk_status("l5_idle_ticks", 6'd0, 1'b0, 1'b0, 1'b0);
    chk("l5_no_expired", 32'(exp_seen), 32'(exp_base));

    // asynchronous reset in the middle of a round
    pulse_start(6'd5);
    ticks(300);
    #2 rst = 1'b0;
    #1;
    chk_status("async_rst", 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    @(negedge clk) rst = 1'b1;
    exp_base = exp_seen;
    step();
    chk("rst_no_expired", 32'(exp_seen), 32'(exp_base));
    pulse_start(6'd1);
    chk_status("rst_l1_start", 6'd1, 1'b1, 1'b0, 1'b0);
    ticks(999);
    chk_status("rst_l1_t999", 6'd1, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_status("rst_l1_t1000", 6'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_l1_expired", 32'(bus.expired), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
